rtc_bus_ctrl: RTL

Bus-cycle generator for the external RTC's 8-bit multiplexed address/data port. It accepts a single read or write request from the control FSM. It then drives the chip-select, read, write and address/data-select strobes through an address phase and a data phase. On reads it returns the captured byte with a one-cycle strobe, which the downstream 8-bit enable register uses to latch it.

---
 rtl/rtc_bus_pkg.sv | 20 ++
 rtl/rtc_phase_timer.sv | 28 ++
 rtl/rtc_bus_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus controller: FSM states,
// default phase length and read/write encodings.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR_ACT,
    ST_ADR_HOLD,
    ST_TURN,
    ST_DAT_ACT,
    ST_DAT_HOLD,
    ST_DONE
  } rtc_state_e;

  localparam int PHASE_CYCLES_DEF = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times each bus phase; zero_o marks the last
// cycle of the phase.
module rtc_phase_timer #(
  parameter int PHASE_CYCLES = 4,
  parameter int CW           = $clog2(PHASE_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle generator for the external RTC's multiplexed address/data port:
// address phase, bus turnaround, data phase, then a one-cycle completion pulse.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYCLES = PHASE_CYCLES_DEF,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              a_d,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid
);

  localparam int CW = $clog2(PHASE_CYCLES + 1);

  rtc_state_e        state_q;
  logic              rw_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ad_out_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ad_oe_q, cs_n_q, rd_n_q, wr_n_q, a_d_q;
  logic              busy_q, done_q, rdata_valid_q;
  logic              advance_d;
  logic              tmr_zero;

  // Every state change reloads the timer, so each timed phase gets a fresh count.
  always_comb begin
    advance_d = 1'b0;
    case (state_q)
      ST_IDLE: advance_d = start;
      ST_DONE: advance_d = 1'b1;
      default: advance_d = tmr_zero;
    endcase
  end

  rtc_phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES),
    .CW          (CW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (advance_d),
    .load_val_i(CW'(PHASE_CYCLES - 1)),
    .zero_o    (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      rw_q    <= rw;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Outputs are set on the transition edge, so they change exactly with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ad_out_q      <= '0;
      ad_oe_q       <= 1'b0;
      cs_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      a_d_q         <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      if (advance_d) begin
        case (state_q)
          ST_IDLE: begin
            state_q  <= ST_ADR_ACT;
            cs_n_q   <= 1'b0;
            a_d_q    <= 1'b0;
            wr_n_q   <= 1'b0;
            ad_oe_q  <= 1'b1;
            ad_out_q <= addr;
            busy_q   <= 1'b1;
          end
          ST_ADR_ACT: begin
            state_q <= ST_ADR_HOLD;
            wr_n_q  <= 1'b1;
          end
          ST_ADR_HOLD: begin
            state_q <= ST_TURN;
            cs_n_q  <= 1'b1;
            ad_oe_q <= 1'b0;
            a_d_q   <= 1'b1;
          end
          ST_TURN: begin
            state_q <= ST_DAT_ACT;
            cs_n_q  <= 1'b0;
            if (rw_q == RW_WRITE) begin
              wr_n_q   <= 1'b0;
              ad_oe_q  <= 1'b1;
              ad_out_q <= wdata_q;
            end else begin
              rd_n_q <= 1'b0;
            end
          end
          ST_DAT_ACT: begin
            state_q <= ST_DAT_HOLD;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            if (rw_q == RW_READ) begin
              rdata_q <= ad_in;
            end
          end
          ST_DAT_HOLD: begin
            state_q       <= ST_DONE;
            cs_n_q        <= 1'b1;
            ad_oe_q       <= 1'b0;
            done_q        <= 1'b1;
            rdata_valid_q <= (rw_q == RW_READ);
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            a_d_q   <= 1'b1;
            ad_oe_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ad_out      = ad_out_q;
  assign ad_oe       = ad_oe_q;
  assign cs_n        = cs_n_q;
  assign rd_n        = rd_n_q;
  assign wr_n        = wr_n_q;
  assign a_d         = a_d_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;

endmodule
